// File: rtl/cim_pkg.sv
// Shared defaults, FSM state encoding and constants for the CIM weight loader.
package cim_pkg;

    localparam int CIM_DATA_W = 24;
    localparam int CIM_ROWS   = 8;
    localparam int CIM_IDX_W  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CHK  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic [CIM_ROWS-1:0] ROW0_ONEHOT = CIM_ROWS'(1);

endpackage

// File: rtl/cim_onehot_dec.sv
// Row index to one-hot word-address decoder; purely combinational.
module cim_onehot_dec #(
    parameter int IDX_W = 3,
    parameter int ROWS  = 8
) (
    input  logic [IDX_W-1:0] idx,
    output logic [ROWS-1:0]  onehot
);

    always_comb begin
        onehot      = '0;
        onehot[idx] = 1'b1;
    end

endmodule

// File: rtl/cim_weight_loader.sv
// Write sequencer for the CIM weight bank: streams weight words onto D/WA, one row per cycle.
// Optional CIM_WLD_CHKSUM_EN: trailing XOR checksum word per burst, mismatch raises sticky err.
module cim_weight_loader
    import cim_pkg::*;
#(
    parameter int DATA_W = CIM_DATA_W,
    parameter int ROWS   = CIM_ROWS,
    parameter int IDX_W  = CIM_IDX_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [IDX_W-1:0]  cfg_base,
    input  logic [IDX_W:0]    cfg_rows,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic [DATA_W-1:0] D,
    output logic [ROWS-1:0]   WA,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [IDX_W:0] ROWS_W = (IDX_W+1)'(ROWS);
    localparam logic [IDX_W:0] ONE_W  = (IDX_W+1)'(1);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [IDX_W:0]    rem_q, rem_d;
    logic [DATA_W-1:0] d_q, d_d;
    logic [ROWS-1:0]   wa_q, wa_d;
    logic              s_ready_q, s_ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
`ifdef CIM_WLD_CHKSUM_EN
    logic [DATA_W-1:0] chk_q, chk_d;
    logic              err_q, err_d;
`endif

    logic [ROWS-1:0]   row_onehot;
    logic [IDX_W:0]    rows_eff;
    logic              hs;

    cim_onehot_dec #(.IDX_W(IDX_W), .ROWS(ROWS)) u_dec (
        .idx    (ptr_q),
        .onehot (row_onehot)
    );

    // 0 and anything above ROWS both mean a whole-bank burst.
    assign rows_eff = (cfg_rows == '0 || cfg_rows > ROWS_W) ? ROWS_W : cfg_rows;
    assign hs       = s_valid && s_ready_q;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        d_d     = d_q;
        wa_d    = wa_q;
`ifdef CIM_WLD_CHKSUM_EN
        chk_d   = chk_q;
        err_d   = err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    ptr_d   = cfg_base;
                    rem_d   = rows_eff;
`ifdef CIM_WLD_CHKSUM_EN
                    chk_d   = '0;
                    err_d   = 1'b0;
`endif
                end
            end
            LOAD: begin
                if (hs) begin
                    d_d   = s_data;
                    wa_d  = row_onehot;
                    ptr_d = ptr_q + 1'b1;
                    rem_d = rem_q - 1'b1;
`ifdef CIM_WLD_CHKSUM_EN
                    chk_d = chk_q ^ s_data;
                    if (rem_q == ONE_W) state_d = CHK;
`else
                    if (rem_q == ONE_W) state_d = DONE;
`endif
                end
            end
`ifdef CIM_WLD_CHKSUM_EN
            // The checksum word is consumed here but never reaches the bank.
            CHK: begin
                if (hs) begin
                    err_d   = (s_data != chk_q);
                    state_d = DONE;
                end
            end
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        s_ready_d = (state_d == LOAD) || (state_d == CHK);
        busy_d    = (state_d != IDLE);
        done_d    = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            rem_q     <= '0;
            d_q       <= '0;
            wa_q      <= ROW0_ONEHOT;
            s_ready_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef CIM_WLD_CHKSUM_EN
            chk_q     <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            rem_q     <= rem_d;
            d_q       <= d_d;
            wa_q      <= wa_d;
            s_ready_q <= s_ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef CIM_WLD_CHKSUM_EN
            chk_q     <= chk_d;
            err_q     <= err_d;
`endif
        end
    end

    assign s_ready = s_ready_q;
    assign D       = d_q;
    assign WA      = wa_q;
    assign busy    = busy_q;
    assign done    = done_q;
`ifdef CIM_WLD_CHKSUM_EN
    assign err     = err_q;
`else
    assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_cim_weight_loader.sv
// Directed + randomized bench for cim_weight_loader with a row-address/bank-content reference model.
module tb_cim_weight_loader;

    localparam int DW = 24;
    localparam int RW = 8;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [IW-1:0] cfg_base;
    logic [IW:0]   cfg_rows;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_ready;
    logic [DW-1:0] D;
    logic [RW-1:0] WA;
    logic          busy, done, err;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] bank_dut [RW];
    logic [DW-1:0] bank_mdl [RW];
    bit            exp_err_q = 1'b0;

    cim_weight_loader dut (
        .clk(clk), .rst(rst), .start(start), .cfg_base(cfg_base), .cfg_rows(cfg_rows),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .D(D), .WA(WA),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int oh2idx(input logic [RW-1:0] v);
        int r = 0;
        for (int i = 0; i < RW; i++) if (v[i]) r = i;
        return r;
    endfunction

    // Level-sensitive bank: whatever WA selects gets D every cycle out of reset.
    always @(posedge clk) if (!rst && $onehot(WA)) bank_dut[oh2idx(WA)] <= D;

    always @(negedge clk) check("wa_onehot", 32'($onehot(WA)), 32'd1);

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_burst(input int base, input int rows);
        cfg_base = IW'(base);
        cfg_rows = (IW+1)'(rows);
        start    = 1'b1;
        step();
        start    = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        check("ready_after_start", 32'(s_ready), 32'd1);
        check("err_cleared", 32'(err), 32'd0);
    endtask

    // exp_row < 0 marks a word that must not reach the bank (checksum).
    task automatic push(input string tag, input logic [DW-1:0] w, input int gap, input int exp_row);
        logic [DW-1:0] d0;
        logic [RW-1:0] wa0;
        int n;
        s_valid = 1'b0;
        d0  = D;
        wa0 = WA;
        repeat (gap) begin
            step();
            check({tag, "_gap_d"}, 32'(D), 32'(d0));
            check({tag, "_gap_wa"}, 32'(WA), 32'(wa0));
        end
        s_valid = 1'b1;
        s_data  = w;
        n = 0;
        while (!s_ready && n < 16) begin
            step();
            n++;
        end
        if (n == 16) check({tag, "_ready_timeout"}, 32'(s_ready), 32'd1);
        step();
        s_valid = 1'b0;
        if (exp_row >= 0) begin
            check({tag, "_wa"}, 32'(WA), 32'(1) << exp_row);
            check({tag, "_d"}, 32'(D), 32'(w));
            bank_mdl[exp_row] = w;
        end else begin
            check({tag, "_chk_wa_hold"}, 32'(WA), 32'(wa0));
            check({tag, "_chk_d_hold"}, 32'(D), 32'(d0));
        end
    endtask

    function automatic logic [DW-1:0] xor_all(input logic [DW-1:0] q[$]);
        logic [DW-1:0] x = '0;
        foreach (q[i]) x ^= q[i];
        return x;
    endfunction

    // gapmode: 0 back-to-back, 1 one idle cycle before every word but the first, 2 random 0..2.
    task automatic burst(input string tag, input int base, input int rows, input int gapmode,
                         input logic [DW-1:0] words[$], input logic [DW-1:0] chkw, input bit exp_e);
        int gap;
        begin_burst(base, rows);
        foreach (words[i]) begin
            gap = (gapmode == 0) ? 0 : (gapmode == 1) ? ((i > 0) ? 1 : 0) : $urandom_range(0, 2);
            push(tag, words[i], gap, (base + i) % RW);
        end
`ifdef CIM_WLD_CHKSUM_EN
        push({tag, "_sum"}, chkw, 0, -1);
        exp_err_q = exp_e;
`else
        exp_err_q = 1'b0;
        if (chkw != chkw || exp_e) exp_err_q = 1'b0;
`endif
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_busy_done"}, 32'(busy), 32'd1);
        check({tag, "_ready_done"}, 32'(s_ready), 32'd0);
        check({tag, "_err"}, 32'(err), 32'(exp_err_q));
        start = 1'b1;  // must be ignored in the DONE cycle
        step();
        start = 1'b0;
        check({tag, "_done_drop"}, 32'(done), 32'd0);
        check({tag, "_busy_drop"}, 32'(busy), 32'd0);
        check({tag, "_err_sticky"}, 32'(err), 32'(exp_err_q));
        step();
        check({tag, "_start_in_done_ignored"}, 32'(busy), 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_wa"}, 32'(WA), 32'h01);
        check({tag, "_d"}, 32'(D), 32'd0);
        check({tag, "_ready"}, 32'(s_ready), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        logic [DW-1:0] q[$];
        logic [DW-1:0] x;
        int base, rows, n;
        bit flip;

        for (int i = 0; i < RW; i++) begin
            bank_dut[i] = '0;
            bank_mdl[i] = '0;
        end
        rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0; cfg_base = '0; cfg_rows = '0;

        // T1 reset
        repeat (3) step();
        rst = 1'b0;
        check_reset_vals("t1_reset");
        step();

        // T2 full bank, contiguous stream 1..8
        q = {};
        for (int i = 0; i < RW; i++) q.push_back(DW'(i + 1));
        burst("t2_full", 0, 0, 0, q, xor_all(q), 1'b0);

        // T3 wrap with stalls
        q = {24'h123456, 24'h654321, 24'hABCDEF};
        burst("t3_wrap", 6, 3, 1, q, xor_all(q), 1'b0);

        // T4 start while busy ignored, then reset mid-burst
        begin_burst(0, 4);
        push("t4_w0", 24'h111111, 0, 0);
        cfg_base = 3'd5; cfg_rows = 4'd1; start = 1'b1;
        step();
        start = 1'b0;
        check("t4_busy_after_restart", 32'(busy), 32'd1);
        push("t4_w1", 24'h222222, 0, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        bank_mdl[0] = '0;
        check_reset_vals("t4_midreset");
        step();
        q = {24'h333333};
        burst("t4_single", 2, 1, 0, q, xor_all(q), 1'b0);

        // Full-bank wrap from row 5 and clamp of oversized row count
        q = {};
        for (int i = 0; i < RW; i++) q.push_back(DW'($urandom));
        burst("wrap5", 5, 8, 0, q, xor_all(q), 1'b0);
        q = {};
        for (int i = 0; i < RW; i++) q.push_back(DW'($urandom));
        burst("clamp13", 3, 13, 2, q, xor_all(q), 1'b0);

`ifdef CIM_WLD_CHKSUM_EN
        // T5 checksum
        q = {24'hA5A5A5, 24'h0F0F0F};
        burst("t5_bad", 0, 2, 0, q, 24'h000000, 1'b1);
        burst("t5_good", 0, 2, 0, q, 24'hAAAAAA, 1'b0);
`endif

        // Randomized bursts
        for (int k = 0; k < 8; k++) begin
            base = $urandom_range(0, RW - 1);
            rows = $urandom_range(0, 15);
            n    = (rows == 0 || rows > RW) ? RW : rows;
            q = {};
            for (int i = 0; i < n; i++) q.push_back(DW'($urandom));
            flip = 1'($urandom_range(0, 1));
            x = xor_all(q) ^ (flip ? DW'($urandom_range(1, 255)) : DW'(0));
            burst("rand", base, rows, 2, q, x, flip);
        end

        // T6 bank contents
        step();
        for (int i = 0; i < RW; i++) check($sformatf("bank_row%0d", i), 32'(bank_dut[i]), 32'(bank_mdl[i]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
